// File: rtl/time_counter.sv
// time_counter: BCD time-of-day clock (HH:MM:SS) with a simple set mode.
//
// A prescaler divides clk by PRESCALE to produce one-second steps while in
// RUN. mode_btn walks RUN -> SET_HOUR -> SET_MIN -> RUN; inc_btn bumps the
// field being set. Leaving SET_MIN restarts the seconds at 00 with a fresh
// prescaler, so the minute boundary lines up with the moment of setting.
//
// Parameters:
//   PRESCALE  clk cycles per one-second step (2..65535)
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   mode_btn  one-cycle pulse, advances the set-mode state
//   inc_btn   one-cycle pulse, increments the field being set
//   sec_bcd   seconds, packed BCD 00..59
//   min_bcd   minutes, packed BCD 00..59
//   hour_bcd  hours, packed BCD 00..23
//   set_mode  00 RUN, 01 SET_HOUR, 10 SET_MIN
//   sec_tick  one-cycle pulse with the first cycle a new RUN seconds value shows
//   day_wrap  one-cycle pulse with the first cycle 00:00:00 shows after 23:59:59
// All outputs come straight from registers.

module time_counter #(
    parameter int PRESCALE = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic [1:0] set_mode,
    output logic       sec_tick,
    output logic       day_wrap
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } mode_t;

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    mode_t       mode_reg,     mode_next;
    logic [15:0] prescale_reg, prescale_next;
    logic [7:0]  sec_reg,      sec_next;
    logic [7:0]  min_reg,      min_next;
    logic [7:0]  hour_reg,     hour_next;
    logic        sec_tick_reg, sec_tick_next;
    logic        day_wrap_reg, day_wrap_next;

    logic [8:0]  sec_inc, min_inc, hour_inc;

    // Packed-BCD increment with roll-over at max_v.
    // Returns {wrapped, next_value}; wrapped is set when max_v rolls to 00.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [8:0] r;
        if (v == max_v) begin
            r = {1'b1, 8'h00};
        end else if (v[3:0] == 4'd9) begin
            r = {1'b0, v[7:4] + 4'd1, 4'h0};
        end else begin
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    assign sec_inc  = bcd_inc(sec_reg,  8'h59);
    assign min_inc  = bcd_inc(min_reg,  8'h59);
    assign hour_inc = bcd_inc(hour_reg, 8'h23);

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_reg     <= RUN;
            prescale_reg <= 16'd0;
            sec_reg      <= 8'h00;
            min_reg      <= 8'h00;
            hour_reg     <= 8'h00;
            sec_tick_reg <= 1'b0;
            day_wrap_reg <= 1'b0;
        end else begin
            mode_reg     <= mode_next;
            prescale_reg <= prescale_next;
            sec_reg      <= sec_next;
            min_reg      <= min_next;
            hour_reg     <= hour_next;
            sec_tick_reg <= sec_tick_next;
            day_wrap_reg <= day_wrap_next;
        end
    end

    always_comb begin
        mode_next     = mode_reg;
        prescale_next = prescale_reg;
        sec_next      = sec_reg;
        min_next      = min_reg;
        hour_next     = hour_reg;
        sec_tick_next = 1'b0;
        day_wrap_next = 1'b0;

        case (mode_reg)
            RUN: begin
                if (mode_btn) begin
                    // Entering set mode wins over a due second step so the
                    // displayed time is carried over unchanged.
                    mode_next     = SET_HOUR;
                    prescale_next = 16'd0;
                end else if (prescale_reg == PS_LAST) begin
                    prescale_next = 16'd0;
                    sec_next      = sec_inc[7:0];
                    sec_tick_next = 1'b1;
                    if (sec_inc[8]) begin
                        min_next = min_inc[7:0];
                        if (min_inc[8]) begin
                            hour_next     = hour_inc[7:0];
                            day_wrap_next = hour_inc[8];
                        end
                    end
                end else begin
                    prescale_next = prescale_reg + 16'd1;
                end
            end
            SET_HOUR: begin
                prescale_next = 16'd0;
                if (mode_btn) begin
                    mode_next = SET_MIN;
                end else if (inc_btn) begin
                    hour_next = hour_inc[7:0];
                end
            end
            SET_MIN: begin
                prescale_next = 16'd0;
                if (mode_btn) begin
                    mode_next = RUN;
                    sec_next  = 8'h00;
                end else if (inc_btn) begin
                    // Minute edits wrap on their own; no carry into hours.
                    min_next = min_inc[7:0];
                end
            end
            default: begin
                mode_next     = RUN;
                prescale_next = 16'd0;
            end
        endcase
    end

    assign sec_bcd  = sec_reg;
    assign min_bcd  = min_reg;
    assign hour_bcd = hour_reg;
    assign set_mode = mode_reg;
    assign sec_tick = sec_tick_reg;
    assign day_wrap = day_wrap_reg;

endmodule
